instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Encoder-side counterpart of the core's RV32I decode path: accepts field-level instruction requests (opcode, funct3, funct7, rd, rs1, rs2, immediate) and packs them into 32-bit RV32I words using the riscv_pkg encodings.
- Buffers encoded words in a small FIFO and streams them into instruction memory over a valid/ready write port with an auto-incrementing address.
- Used as a boot/program loader and as a verification stimulus source for the core.

Parameters:
- DEPTH, 4, encoded-word FIFO entries (power of 2, >=2)
- CNT_W, 16, width of written-word counter

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  synchronous active-low reset
- start_i  in  1  load write address from start_addr_i, clear counter and error flag
- start_addr_i  in  32  first write address (word aligned; bits[1:0] ignored)
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_opcode_i  in  7  opcode_t value
- req_funct3_i  in  3  funct3
- req_funct7_i  in  7  funct7 (ALU, and ALU_I shifts only)
- req_rd_i, req_rs1_i, req_rs2_i  in  5 each  register indices
- req_imm_i  in  32  immediate, byte-offset form, sign-extended
- mem_wr_valid_o  out  1  write valid
- mem_wr_ready_i  in  1  memory accepts write
- mem_wr_addr_o  out  32  write address
- mem_wr_data_o  out  32  encoded instruction
- idle_o  out  1  FIFO empty
- written_cnt_o  out  CNT_W  completed writes since reset/start, saturating
- err_o  out  1  sticky illegal-request flag

Behaviour:
- Reset (rstn_i=0 at a clk edge):
  - FIFO empty; write address 0.
  - All outputs 0, except req_ready_o=1 and idle_o=1.
  - Reset mid-stream discards queued words; no partial write is retained.
- Encoding is combinational on the request. The encoded word is pushed into the FIFO on handshake.
- Field placement by opcode:
  - ALU: {f7, rs2, rs1, f3, rd, op}. Covers F7_ALU_NORMAL/F7_ALU_MODIFIED/F7_MUL.
  - ALU_I: {imm[11:0], rs1, f3, rd, op}. For f3 SLL or SRL_SRA, bits[31:25]=f7 and bits[24:20]=imm[4:0].
  - LW: I-type, f3 forced to 3'b010.
  - SW: {imm[11:5], rs2, rs1, 3'b010, imm[4:0], op}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - LUI/AUIPC: {imm[31:12], rd, op}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - Unused fields are ignored. imm[0] is ignored for BRANCH/JAL. Higher immediate bits are truncated without check.
- Illegal requests: opcode not in opcode_t, BRANCH with f3 010/011, or ALU with f7 not in f7_alu_modifier_t.
  - Encoded as NOP_INSTR_HEX (0x00000033).
  - err_o set the next cycle and held until reset or start_i.
- req_ready_o = (FIFO count < DEPTH) & ~start_i. No combinational path from mem_wr_ready_i.
- Write port:
  - mem_wr_valid_o = ~empty; mem_wr_data_o = FIFO head.
  - Outputs are held stable while valid & ~ready.
  - Latency: a request accepted at edge N into an empty FIFO is presented at cycle N+1.
- On each write handshake: pop the FIFO; address += 4 (wraps 0xFFFFFFFC->0); written_cnt_o += 1, saturating at all-ones.
- Simultaneous push and pop when full: push is refused (ready low when full). Push and pop on a non-full FIFO both occur; count unchanged.
- start_i:
  - Honoured only when idle_o=1 and mem_wr_valid_o=0. Otherwise ignored (address, count and err unchanged).
  - Blocks request acceptance in its cycle.
  - Effect: address=start_addr_i with bits[1:0] cleared; written_cnt_o=0; err_o=0.
- Pointer wrap: modulo DEPTH. Full and empty are distinguished by an extra pointer bit.

Test Plan:
- Reset, start_i with start_addr 0x1000, ADDI x1,x0,5 (op 0010011, f3 000, rd1, rs1 0, imm 5), mem_wr_ready_i=1 -> write addr 0x1000, data 0x00500093, one cycle after acceptance; written_cnt_o=1.
- SW x2,8(x1), then BEQ x1,x2,-4 -> data 0x0020A423 @0x1000, then 0xFE208EE3 @0x1004.
- JAL x1,+8, then MUL x3,x1,x2 (op ALU, f7 0000001, f3 000) -> 0x008000EF, then 0x022081B3.
- DEPTH=4, mem_wr_ready_i=0, 5 requests offered -> req_ready_o low after 4 accepted. Release ready -> 4 words at 0x1000..0x100C in order, then the 5th at 0x1010; data held stable while stalled.
- Opcode 0x7F, and BRANCH with f3 010 -> both write 0x00000033; err_o=1 from the cycle after the first illegal request until the next honoured start_i.
- start_i asserted while the FIFO is non-empty -> ignored, address sequence unbroken. Assert rstn_i=0 mid-stream -> mem_wr_valid_o=0, idle_o=1, written_cnt_o=0 on the next cycle.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write bundle for instr_encoder_loader.
//   req_*    : field-level instruction request (valid/ready handshake)
//   mem_wr_* : encoded-word write port toward instruction memory (valid/ready)
// Modports:
//   slave  : the loader (consumes requests, drives memory writes)
//   master : the requester/memory side (drives requests, accepts writes)
interface instr_encoder_loader_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;

  modport slave (
    input  req_valid, req_opcode, req_funct3, req_funct7, req_rd, req_rs1, req_rs2, req_imm,
    input  mem_wr_ready,
    output req_ready, mem_wr_valid, mem_wr_addr, mem_wr_data
  );

  modport master (
    output req_valid, req_opcode, req_funct3, req_funct7, req_rd, req_rs1, req_rs2, req_imm,
    output mem_wr_ready,
    input  req_ready, mem_wr_valid, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and program loader.
// Packs field-level requests into 32-bit RV32I words, buffers them in a DEPTH-entry FIFO and
// streams them to instruction memory at an auto-incrementing word address.
// Ports:
//   clk_i, rstn_i  : clock, synchronous active-low reset
//   start_i        : load write address, clear counter and error (only while fully idle)
//   start_addr_i   : first write address, bits[1:0] ignored
//   bus_io         : request handshake and memory write port (slave side)
//   idle_o         : FIFO empty
//   written_cnt_o  : completed writes since reset/start, saturating
//   err_o          : sticky illegal-request flag
module instr_encoder_loader #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [31:0]           start_addr_i,
  instr_encoder_loader_if.slave bus_io,
  output logic                  idle_o,
  output logic [CNT_W-1:0]      written_cnt_o,
  output logic                  err_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [6:0] OpAlu    = 7'b0110011;
  localparam logic [6:0] OpAluI   = 7'b0010011;
  localparam logic [6:0] OpLw     = 7'b0000011;
  localparam logic [6:0] OpSw     = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [6:0] F7AluNormal   = 7'b0000000;
  localparam logic [6:0] F7AluModified = 7'b0100000;
  localparam logic [6:0] F7Mul         = 7'b0000001;

  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3SrlSra = 3'b101;
  localparam logic [2:0] F3Word   = 3'b010;

  localparam logic [31:0] NopInstr = 32'h0000_0033;

  localparam logic [AW:0]      PtrOne = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  // Request fields
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  assign op  = bus_io.req_opcode;
  assign f3  = bus_io.req_funct3;
  assign f7  = bus_io.req_funct7;
  assign rd  = bus_io.req_rd;
  assign rs1 = bus_io.req_rs1;
  assign rs2 = bus_io.req_rs2;
  assign imm = bus_io.req_imm;

  // Combinational encoder
  logic [31:0] enc_word;
  logic        enc_illegal;

  always_comb begin
    enc_word    = NopInstr;
    enc_illegal = 1'b0;
    case (op)
      OpAlu: begin
        if (f7 == F7AluNormal || f7 == F7AluModified || f7 == F7Mul) begin
          enc_word = {f7, rs2, rs1, f3, rd, op};
        end else begin
          enc_illegal = 1'b1;
        end
      end
      OpAluI: begin
        // Shift-immediates carry funct7 in the upper immediate slot
        if (f3 == F3Sll || f3 == F3SrlSra) begin
          enc_word = {f7, imm[4:0], rs1, f3, rd, op};
        end else begin
          enc_word = {imm[11:0], rs1, f3, rd, op};
        end
      end
      OpLw:     enc_word = {imm[11:0], rs1, F3Word, rd, op};
      OpSw:     enc_word = {imm[11:5], rs2, rs1, F3Word, imm[4:0], op};
      OpBranch: begin
        if (f3 == 3'b010 || f3 == 3'b011) begin
          enc_illegal = 1'b1;
        end else begin
          enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        end
      end
      OpLui, OpAuipc: enc_word = {imm[31:12], rd, op};
      OpJal:    enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default:  enc_illegal = 1'b1;
    endcase
    if (enc_illegal) begin
      enc_word = NopInstr;
    end
  end

  // FIFO state; the extra pointer bit separates full from empty
  logic [31:0]      fifo_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic empty, full, push, pop, start_ok;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign start_ok = start_i & empty;

  // Ready depends only on local state and start_i, never on mem_wr_ready
  assign bus_io.req_ready = ~full & ~start_i;
  assign push             = bus_io.req_valid & bus_io.req_ready;
  assign pop              = ~empty & bus_io.mem_wr_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
      if (enc_illegal) begin
        err_d = 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
      addr_d   = addr_q + 32'd4;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CntOne;
      end
    end
    // start_ok implies an empty FIFO, so it never collides with a pop
    if (start_ok) begin
      addr_d = start_addr_i & 32'hFFFF_FFFC;
      cnt_d  = '0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: entries are only visible between push and pop
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q[AW-1:0]] <= enc_word;
    end
  end

  assign bus_io.mem_wr_valid = ~empty;
  assign bus_io.mem_wr_addr  = addr_q;
  assign bus_io.mem_wr_data  = empty ? 32'h0 : fifo_q[rd_ptr_q[AW-1:0]];
  assign idle_o              = empty;
  assign written_cnt_o       = cnt_q;
  assign err_o               = err_q;

endmodule
